// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one cmd becomes one AXI transaction, minimum 3 cycles cmd->rsp.
// All AXI/rsp outputs are registered; the slave and rsp_ready can stall each phase indefinitely.
module axi4_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // command / response side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AXI4-Lite master
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                aw_hs, w_hs;

  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W may complete in either order or together
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          rsp_resp_d  = bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // The held address serves both AW and AR; only one of them is ever valid.
  assign cmd_ready = (state_q == IDLE);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: memory-backed AXI slave with configurable stalls, word-level reference model.
module tb_axi4_lite_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  // slave configuration
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  bit rand_en;
  logic [1:0] resp_cfg;

  // slave state and monitor observations
  logic [31:0] smem [16];
  logic [31:0] mmem [16];
  int cyc;
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  bit got_aw, got_w, pend_b, pend_r;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int aw_hs_n, w_hs_n, ar_hs_n;
  int aw_hs_cyc, w_hs_cyc, ar_hs_cyc, aw_last_vld, w_last_vld, b_rise_cyc;
  logic [31:0] aw_hs_addr, w_hs_data;
  int stab_viol;
  bit aw_pend, w_pend, ar_pend, prev_bready;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic [3:0]  ws_prev;

  initial begin
    cyc = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
    got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0;
    aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; stab_viol = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; prev_bready = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (awvalid) aw_last_vld = cyc;
      if (wvalid)  w_last_vld  = cyc;
      if (bready && !prev_bready) b_rise_cyc = cyc;
      prev_bready = bready;
      if (!reset) begin
        if (aw_pend && (!awvalid || awaddr !== aw_prev)) stab_viol++;
        if (w_pend && (!wvalid || wdata !== w_prev || wstrb !== ws_prev)) stab_viol++;
        if (ar_pend && (!arvalid || araddr !== ar_prev)) stab_viol++;
      end
      aw_pend = awvalid && !awready; aw_prev = awaddr;
      w_pend  = wvalid && !wready;   w_prev = wdata; ws_prev = wstrb;
      ar_pend = arvalid && !arready; ar_prev = araddr;
      if (awvalid && awready) begin
        aw_hs_n++; aw_hs_cyc = cyc; aw_hs_addr = awaddr; s_awaddr = awaddr; got_aw = 1; aw_cnt = 0;
        if (rand_en) aw_dly = $urandom_range(0, 3);
      end else if (awvalid) aw_cnt++;
      if (wvalid && wready) begin
        w_hs_n++; w_hs_cyc = cyc; w_hs_data = wdata; s_wdata = wdata; s_wstrb = wstrb; got_w = 1; w_cnt = 0;
        if (rand_en) w_dly = $urandom_range(0, 3);
      end else if (wvalid) w_cnt++;
      if (bvalid && bready) pend_b = 0;
      if (got_aw && got_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        got_aw = 0; got_w = 0; pend_b = 1;
        b_wait = rand_en ? $urandom_range(0, 3) : b_dly;
      end
      if (rvalid && rready) pend_r = 0;
      if (arvalid && arready) begin
        ar_hs_n++; ar_hs_cyc = cyc; s_araddr = araddr; ar_cnt = 0; pend_r = 1;
        r_wait = rand_en ? $urandom_range(0, 3) : r_dly;
        if (rand_en) ar_dly = $urandom_range(0, 3);
      end else if (arvalid) ar_cnt++;
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end
      awready = (aw_cnt >= aw_dly);
      wready  = (w_cnt >= w_dly);
      arready = (ar_cnt >= ar_dly);
      if (!pend_b) bvalid = 0;
      else if (!bvalid) begin
        if (b_wait == 0) begin bvalid = 1; bresp = resp_cfg; end
        else b_wait--;
      end
      if (!pend_r) rvalid = 0;
      else if (!rvalid) begin
        if (r_wait == 0) begin rvalid = 1; rresp = resp_cfg; rdata = smem[s_araddr[5:2]]; end
        else r_wait--;
      end
    end
  end

  task automatic ideal_slave();
    rand_en = 0; aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; resp_cfg = 2'b00;
  endtask

  // Reference model: a word memory updated per command in issue order.
  task automatic model_apply(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] rc, output logic ew, output logic [31:0] ed, output logic [1:0] er);
    ew = wr; er = rc;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (s[b]) mmem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      ed = 32'h0;
    end else ed = mmem[a[5:2]];
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, output int c0, output int lat, output bit ok, output int hold_bad,
                         output logic rw, output logic [31:0] rd, output logic [1:0] rr);
    ok = 0; c0 = -1; lat = -1; hold_bad = 0; rw = 1'bx; rd = 'x; rr = 'x;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin c0 = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    if (c0 < 0) return;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; lat = cyc - c0; break; end
    end
    if (!ok) return;
    rw = rsp_write; rd = rsp_rdata; rr = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_write !== rw || rsp_rdata !== rd || rsp_resp !== rr || cmd_ready !== 1'b0)
        hold_bad++;
    end
    @(posedge clk); #1; rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
  endtask

  int c0, lat, hb;
  bit ok;
  logic rw, ew;
  logic [31:0] rd, ed;
  logic [1:0] rr, er;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== 35'h0) begin
      errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_write, rsp_rdata, rsp_resp});
    end
    checks++;
    if ({awaddr, araddr, wdata, wstrb} !== 100'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {awaddr, araddr, wdata, wstrb});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_ideal();
    ideal_slave();
    model_apply(1, 32'h10, 32'hDEADBEEF, 4'hF, resp_cfg, ew, ed, er);
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, c0, lat, ok, hb, rw, rd, rr);
    checks++;
    if (!ok || lat != 3) begin errors++; $display("FAIL wr_latency: got ok=%0d lat=%0d expected lat=3", ok, lat); end
    checks++;
    if (aw_hs_cyc != c0 + 1 || aw_hs_addr !== 32'h10) begin
      errors++; $display("FAIL wr_aw: got cyc %0d addr %h expected cyc %0d addr 00000010", aw_hs_cyc, aw_hs_addr, c0 + 1);
    end
    checks++;
    if (w_hs_cyc != c0 + 1 || w_hs_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_w: got cyc %0d data %h expected cyc %0d data deadbeef", w_hs_cyc, w_hs_data, c0 + 1);
    end
    checks++;
    if ({rw, rd, rr} !== {ew, ed, er}) begin
      errors++; $display("FAIL wr_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b", rw, rd, rr, ew, ed, er);
    end
  endtask

  task automatic test_split_aw_w();
    int aw0, w0;
    logic [31:0] d;
    ideal_slave(); w_dly = 3;
    d = $urandom(); aw0 = aw_hs_n; w0 = w_hs_n;
    model_apply(1, 32'h24, d, 4'b0101, resp_cfg, ew, ed, er);
    run_txn(1, 32'h24, d, 4'b0101, 0, c0, lat, ok, hb, rw, rd, rr);
    checks++;
    if (!ok || aw_last_vld != c0 + 1 || w_last_vld != c0 + 4) begin
      errors++; $display("FAIL split_valids: got aw_last %0d w_last %0d expected %0d %0d", aw_last_vld, w_last_vld, c0 + 1, c0 + 4);
    end
    checks++;
    if (b_rise_cyc != c0 + 5) begin errors++; $display("FAIL split_bready: got %0d expected %0d", b_rise_cyc, c0 + 5); end
    checks++;
    if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin
      errors++; $display("FAIL split_hs_count: got aw %0d w %0d expected 1 1", aw_hs_n - aw0, w_hs_n - w0);
    end
    checks++;
    if ({rw, rd, rr} !== {ew, ed, er}) begin
      errors++; $display("FAIL split_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b", rw, rd, rr, ew, ed, er);
    end
  endtask

  task automatic test_read_stall();
    ideal_slave(); ar_dly = 3; r_dly = 2; resp_cfg = 2'b10;
    smem[12] = 32'h12345678; mmem[12] = 32'h12345678;
    model_apply(0, 32'h30, 32'h0, 4'h0, resp_cfg, ew, ed, er);
    run_txn(0, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, c0, lat, ok, hb, rw, rd, rr);
    checks++;
    if ({rw, rd, rr} !== {1'b0, 32'h12345678, 2'b10} || {rw, rd, rr} !== {ew, ed, er}) begin
      errors++; $display("FAIL rd_rsp: got w=%b d=%h r=%b expected w=0 d=12345678 r=10", rw, rd, rr);
    end
    checks++;
    if (ar_hs_cyc != c0 + 4 || lat != 8) begin
      errors++; $display("FAIL rd_timing: got ar %0d lat %0d expected ar %0d lat 8", ar_hs_cyc, lat, c0 + 4);
    end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL rd_stable: got %0d violations expected 0", stab_viol); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    ideal_slave(); resp_cfg = 2'b11; d = $urandom();
    model_apply(1, 32'h08, d, 4'b1100, resp_cfg, ew, ed, er);
    run_txn(1, 32'h08, d, 4'b1100, 5, c0, lat, ok, hb, rw, rd, rr);
    checks++;
    if (!ok || hb != 0) begin errors++; $display("FAIL bp_hold: got ok=%0d bad=%0d expected ok=1 bad=0", ok, hb); end
    checks++;
    if ({rw, rd, rr} !== {ew, ed, er}) begin
      errors++; $display("FAIL bp_rsp: got w=%b d=%h r=%b expected w=%b d=%h r=%b", rw, rd, rr, ew, ed, er);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic [34:0] expq [$];
    logic [34:0] e;
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic [3:0]  s [4];
    int idx, got;
    bit acc_now;
    ideal_slave();
    for (int i = 0; i < 4; i++) begin
      a[i] = {$urandom_range(0, 255), 4'($urandom_range(0, 15)), 2'b00} & 32'hFFFF_FFFC;
      d[i] = $urandom(); s[i] = 4'($urandom_range(1, 15));
    end
    a[1] = a[0];
    idx = 0; got = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = a[0]; cmd_wdata = d[0]; cmd_wstrb = s[0]; rsp_ready = 1;
    for (int n = 0; n < 60 && got < 4; n++) begin
      @(negedge clk);
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        acc.push_back(cyc);
        model_apply(cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, resp_cfg, ew, ed, er);
        expq.push_back({ew, ed, er});
      end
      if (rsp_valid && rsp_ready) begin
        got++;
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        checks++;
        if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
          errors++; $display("FAIL b2b_rsp%0d: got %h expected %h", got, {rsp_write, rsp_rdata, rsp_resp}, e);
        end
      end
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) begin
          cmd_write = ~idx[0]; cmd_addr = a[idx]; cmd_wdata = d[idx]; cmd_wstrb = s[idx];
        end else cmd_valid = 0;
      end
    end
    cmd_valid = 0; rsp_ready = 0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d responses expected 4", got); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 4) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 4", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    bit wr;
    logic [31:0] a, d;
    logic [3:0] s;
    int bad = 0;
    ideal_slave(); rand_en = 1;
    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom_range(0, 1)); a = $urandom() & 32'hFFFF_FFFC; d = $urandom();
      s = 4'($urandom_range(0, 15)); resp_cfg = 2'($urandom_range(0, 3));
      model_apply(wr, a, d, s, resp_cfg, ew, ed, er);
      run_txn(wr, a, d, s, $urandom_range(0, 2), c0, lat, ok, hb, rw, rd, rr);
      checks++;
      if (!ok || hb != 0 || {rw, rd, rr} !== {ew, ed, er}) begin
        errors++; bad++;
        $display("FAIL rand%0d: got ok=%0d hold=%0d w=%b d=%h r=%b expected w=%b d=%h r=%b",
                 i, ok, hb, rw, rd, rr, ew, ed, er);
      end
    end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL rand_stable: got %0d violations expected 0", stab_viol); end
    rand_en = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    ideal_slave(); b_dly = 10;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3C; cmd_wdata = $urandom(); cmd_wstrb = 4'hF;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1; cmd_valid = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bready) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_bready: got bready never high expected high"); end
    #2 reset = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_async: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle: got cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
    ideal_slave();
    model_apply(0, 32'h04, 32'h0, 4'h0, resp_cfg, ew, ed, er);
    run_txn(0, 32'h04, 32'h0, 4'h0, 0, c0, lat, ok, hb, rw, rd, rr);
    checks++;
    if (!ok || lat != 3 || {rw, rd, rr} !== {ew, ed, er}) begin
      errors++; $display("FAIL rst_mid_recover: got ok=%0d lat=%0d d=%h expected lat=3 d=%h", ok, lat, rd, ed);
    end
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    ideal_slave();
    for (int i = 0; i < 16; i++) begin smem[i] = $urandom(); mmem[i] = smem[i]; end
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset();
    test_write_ideal();
    test_split_aw_w();
    test_read_stall();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master that converts simple request/response commands into AXI4-Lite transactions. It sits directly upstream of `axi4_slave`, driving its AW/W/B/AR/R channels. Its other side faces the NoC network interface. It holds one transaction at a time, registers every AXI output, and returns the slave's response with write/read status.

## Interface
- ADDR_W, 32, address width (cmd_addr, awaddr, araddr)
- DATA_W, 32, data width; STRB_W = DATA_W/8 is derived, not overridable
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- cmd_wstrb  in  STRB_W  byte strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP from the slave
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master directions and widths, matching the `axi4_slave` port list

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1 in IDLE only; cmd_ready is a decode of the state.
  - On cmd_valid, latch addr/wdata/wstrb/write into holding registers.
  - Write command → WR_ADDR_DATA with awvalid = wvalid = 1.
  - Read command → RD_ADDR with arvalid = 1.
- WR_ADDR_DATA:
  - AW and W handshakes are tracked independently with flags aw_done and w_done.
  - awvalid drops the cycle after awready is sampled high; wvalid likewise.
  - When both are done (same or different cycles), go to WR_RESP with bready = 1. Flags are cleared.
  - Valids never drop before their handshake.
  - awaddr/wdata/wstrb stay stable while their valid is high.
- WR_RESP: on bvalid & bready, capture bresp, set rsp_write = 1 and rsp_rdata = 0, drop bready, go to RESP.
- RD_ADDR: on arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata and rresp, set rsp_write = 0, drop rready, go to RESP.
- RESP:
  - rsp_valid = 1 and outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new command is accepted in the same cycle (cmd_ready only in IDLE).
- Response codes (2'b10 SLVERR, 2'b11 DECERR) are passed through unmodified. The master never retries and never generates its own error.
- No timeout: the FSM waits indefinitely on the slave.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - awvalid = wvalid = arvalid = bready = rready = 0.
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0.
  - awaddr = araddr = wdata = wstrb = 0.
  - Reset mid-transaction abandons it with no response. The bench must also reset the slave.
- All AXI and rsp outputs are registered; there is no combinational path from AXI inputs to AXI outputs.
- cmd_ready is the only output that is a state decode.
- Minimum write latency, with awready, wready and bvalid all high and cycle 0 as the cmd handshake:
  - Cycle 1: aw/w valid and handshake.
  - Cycle 2: bready and B handshake.
  - Cycle 3: rsp_valid.
- Minimum read latency, with arready and rvalid high:
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: rsp_valid.
- Back-to-back throughput: one transaction per 4 cycles minimum. After the rsp handshake, 1 IDLE cycle precedes the next cmd acceptance.
- Simultaneous awready/wready in the same cycle: both flags set, and the FSM goes to WR_RESP next cycle.
- bvalid asserted before bready: it is held by the slave and accepted on the first cycle in WR_RESP.

## Test plan
- Write, all slave readies high: cmd write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF → awaddr = 0x10 and wdata = 0xDEADBEEF on cycle 1; rsp_valid on cycle 3 with rsp_write = 1, rsp_resp = 0, rsp_rdata = 0.
- Split AW/W: awready high at cycle 1, wready delayed to cycle 4 → awvalid low from cycle 2, wvalid high through cycle 4, bready rises at cycle 5; exactly one AW and one W handshake.
- Read with stalls: arready delayed 3 cycles, rvalid delayed 2 more, rdata 0x12345678, rresp 2'b10 → rsp_rdata = 0x12345678, rsp_resp = 2'b10, rsp_write = 0; araddr stable for the whole arvalid window.
- Response backpressure: rsp_ready low for 5 cycles → rsp_* stable, cmd_ready = 0 throughout; after the handshake, cmd_ready = 1 the next cycle.
- Back-to-back: 4 alternating write/read commands with cmd_valid held high and an ideal slave → rsp order matches cmd order; each transaction takes exactly 4 cycles.
- Reset asserted in WR_RESP while bready is high → all AXI valids/readies and rsp_valid are 0 immediately (same cycle, asynchronous). After release, state is IDLE with cmd_ready = 1.
